uart_rx_oversample: RTL and testbench

UART_RX_OVERSAMPLE -- requirements
Module: uart_rx_oversample

---
 rtl/uart_rx_oversample.sv | 218 +++++++++++++++++++++
 tb/tb_uart_rx_oversample.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_oversample.sv
// ----------------------------------------------------------------------------
// uart_rx_oversample
// Oversampling UART receiver. The serial line is synchronized, then a
// five-state FSM (IDLE/START/DATA/STOP/BREAK) times each bit with a tick
// counter that advances only on rx_tick cycles. Every bit is decided by a
// 2-of-3 majority vote of the samples taken around the bit centre.
//
// Ports
//   clk        board clock, all logic on posedge
//   reset      synchronous active-high reset
//   rx_tick    one-clk enable pulse at OVERSAMPLE x baud
//   rx         asynchronous serial input, idle high
//   data       last correctly framed word, LSB received first
//   valid      one-clk pulse, data updated on the same cycle
//   frame_err  one-clk pulse when the stop bit votes 0
//   busy       high whenever the FSM is not IDLE
// ----------------------------------------------------------------------------
module uart_rx_oversample #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS + 1);
    localparam int MID = OVERSAMPLE / 2 - 1;

    localparam logic [CW-1:0] C_S0   = CW'(MID - 1);
    localparam logic [CW-1:0] C_S1   = CW'(MID);
    localparam logic [CW-1:0] C_DEC  = CW'(MID + 1);
    localparam logic [CW-1:0] C_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    logic                 r_rx_meta;
    logic                 r_rx_s;
    state_t               r_state;
    logic [CW-1:0]        r_cnt;
    logic [BW-1:0]        r_bitcnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_s0;
    logic                 r_s1;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_frame_err;
    logic                 r_busy;

    state_t               w_state_n;
    logic [CW-1:0]        w_cnt_n;
    logic [BW-1:0]        w_bitcnt_n;
    logic [DATA_BITS-1:0] w_shift_n;
    logic                 w_s0_n;
    logic                 w_s1_n;
    logic [DATA_BITS-1:0] w_data_n;
    logic                 w_valid_n;
    logic                 w_frame_err_n;
    logic                 w_vote;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // The third vote sample is the live synchronized value at the decision count.
    assign w_vote = maj3(r_s0, r_s1, r_rx_s);

    // Two-flop synchronizer for the asynchronous line; idles high.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // Next-state, bit timing, vote capture and output pulse decode.
    always_comb begin
        w_state_n     = r_state;
        w_cnt_n       = r_cnt;
        w_bitcnt_n    = r_bitcnt;
        w_shift_n     = r_shift;
        w_s0_n        = r_s0;
        w_s1_n        = r_s1;
        w_data_n      = r_data;
        w_valid_n     = 1'b0;
        w_frame_err_n = 1'b0;

        if (rx_tick) begin
            if (r_cnt == C_LAST) begin
                w_cnt_n = '0;
            end else begin
                w_cnt_n = r_cnt + CW'(1);
            end

            if (r_cnt == C_S0) begin
                w_s0_n = r_rx_s;
            end else if (r_cnt == C_S1) begin
                w_s1_n = r_rx_s;
            end else begin
                w_s0_n = r_s0;
            end

            case (r_state)
                ST_IDLE: begin
                    w_cnt_n = '0;
                    if (!r_rx_s) begin
                        w_state_n = ST_START;
                    end else begin
                        w_state_n = ST_IDLE;
                    end
                end
                ST_START: begin
                    // A start bit that votes high was a glitch: give up early.
                    if (r_cnt == C_DEC && w_vote) begin
                        w_state_n = ST_IDLE;
                        w_cnt_n   = '0;
                    end else if (r_cnt == C_LAST) begin
                        w_state_n  = ST_DATA;
                        w_cnt_n    = '0;
                        w_bitcnt_n = '0;
                    end else begin
                        w_state_n = ST_START;
                    end
                end
                ST_DATA: begin
                    if (r_cnt == C_DEC) begin
                        w_shift_n  = {w_vote, r_shift[DATA_BITS-1:1]};
                        w_bitcnt_n = r_bitcnt + BW'(1);
                    end else if (r_cnt == C_LAST && r_bitcnt == B_LAST) begin
                        w_state_n = ST_STOP;
                        w_cnt_n   = '0;
                    end else begin
                        w_state_n = ST_DATA;
                    end
                end
                ST_STOP: begin
                    // Leaving at mid-stop lets a following start edge be caught at once.
                    if (r_cnt == C_DEC) begin
                        w_cnt_n = '0;
                        if (w_vote) begin
                            w_data_n  = r_shift;
                            w_valid_n = 1'b1;
                            w_state_n = ST_IDLE;
                        end else begin
                            w_frame_err_n = 1'b1;
                            w_state_n     = ST_BREAK;
                        end
                    end else begin
                        w_state_n = ST_STOP;
                    end
                end
                ST_BREAK: begin
                    w_cnt_n = '0;
                    if (r_rx_s) begin
                        w_state_n = ST_IDLE;
                    end else begin
                        w_state_n = ST_BREAK;
                    end
                end
                default: begin
                    w_state_n = ST_IDLE;
                    w_cnt_n   = '0;
                end
            endcase
        end else begin
            w_state_n = r_state;
        end
    end

    // FSM state, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_bitcnt    <= '0;
            r_shift     <= '0;
            r_s0        <= 1'b1;
            r_s1        <= 1'b1;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_cnt       <= w_cnt_n;
            r_bitcnt    <= w_bitcnt_n;
            r_shift     <= w_shift_n;
            r_s0        <= w_s0_n;
            r_s1        <= w_s1_n;
            r_data      <= w_data_n;
            r_valid     <= w_valid_n;
            r_frame_err <= w_frame_err_n;
            r_busy      <= (w_state_n != ST_IDLE);
        end
    end

    assign data      = r_data;
    assign valid     = r_valid;
    assign frame_err = r_frame_err;
    assign busy      = r_busy;

endmodule

// File: tb/tb_uart_rx_oversample.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_oversample
// Drives 8N1 frames at OVERSAMPLE=16 with directed scenarios followed by
// randomized frames (random payload, tick spacing, idle gaps, glitches and
// broken stop bits). The reference model is a queue of expected events
// (good word or framing error) pushed per frame and popped on each pulse.
// ----------------------------------------------------------------------------
module tb_uart_rx_oversample;

    localparam int DB = 8;
    localparam int OS = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          rx_tick;
    logic          rx;
    logic [DB-1:0] data;
    logic          valid;
    logic          frame_err;
    logic          busy;

    typedef struct {
        bit            err;
        logic [DB-1:0] d;
    } ev_t;

    ev_t           exp_q[$];
    logic [DB-1:0] last_good;
    int            k_div;
    int            n_checks;
    int            n_fail;
    bit            prev_pulse;

    uart_rx_oversample #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_tick   (rx_tick),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // One tick period: tick high for one clk, then k_div-1 quiet clks.
    task automatic one_tick();
        rx_tick = 1'b1;
        @(negedge clk);
        rx_tick = 1'b0;
        repeat (k_div - 1) @(negedge clk);
    endtask

    task automatic hold_line(input logic v, input int n);
        rx = v;
        for (int t = 0; t < n; t++) one_tick();
    endtask

    // gpos < 0 means no glitch; otherwise the line is inverted for that one tick.
    task automatic send_bit(input logic v, input int gpos);
        for (int t = 0; t < OS; t++) begin
            rx = (t == gpos) ? ~v : v;
            one_tick();
        end
    endtask

    function automatic int pick_glitch(input int gmode);
        if (gmode == 1) return 10;
        if (gmode == 2 && $urandom_range(0, 9) < 3) return int'($urandom_range(6, 12));
        return -1;
    endfunction

    task automatic send_frame(input logic [DB-1:0] d, input int gmode);
        ev_t e;
        e.err = 1'b0;
        e.d   = d;
        exp_q.push_back(e);
        send_bit(1'b0, pick_glitch(gmode));
        for (int i = 0; i < DB; i++) send_bit(d[i], pick_glitch(gmode));
        send_bit(1'b1, pick_glitch(gmode));
    endtask

    // Frame whose stop bit is held low for stop_bits bit periods before release.
    task automatic send_bad_frame(input logic [DB-1:0] d, input int stop_bits);
        ev_t e;
        e.err = 1'b1;
        e.d   = '0;
        exp_q.push_back(e);
        send_bit(1'b0, -1);
        for (int i = 0; i < DB; i++) send_bit(d[i], -1);
        hold_line(1'b0, stop_bits * OS);
        check_value("break_busy_high", busy, 1);
        hold_line(1'b1, 6);
        check_value("break_busy_low", busy, 0);
    endtask

    // Output monitor: compares every valid/frame_err pulse against the model.
    initial begin
        ev_t e;
        prev_pulse = 1'b0;
        forever begin
            @(negedge clk);
            if (valid || frame_err) begin
                check_value("pulse_exclusive", valid & frame_err, 0);
                check_value("pulse_width", prev_pulse, 0);
                if (exp_q.size() == 0) begin
                    check_value("unexpected_pulse", {valid, frame_err}, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_value("pulse_kind", frame_err, e.err);
                    if (e.err) begin
                        check_value("data_hold", data, last_good);
                    end else begin
                        check_value("data", data, e.d);
                        last_good = e.d;
                    end
                end
            end
            prev_pulse = valid | frame_err;
        end
    end

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        last_good = '0;
        k_div     = 1;
        reset     = 1'b1;
        rx_tick   = 1'b0;
        rx        = 1'b1;
        repeat (4) @(negedge clk);
        check_value("rst_data", data, 0);
        check_value("rst_valid", valid, 0);
        check_value("rst_frame_err", frame_err, 0);
        check_value("rst_busy", busy, 0);
        reset = 1'b0;
        hold_line(1'b1, 8);

        // Single clean frame, tick every clk.
        send_frame(8'h55, 0);
        check_value("frame55_seen", exp_q.size(), 0);
        hold_line(1'b1, 4);
        check_value("frame55_busy", busy, 0);
        check_value("frame55_data", data, 8'h55);

        // Back-to-back frames with no idle gap.
        send_frame(8'hA3, 0);
        send_frame(8'h0F, 0);
        hold_line(1'b1, 4);
        check_value("b2b_seen", exp_q.size(), 0);
        check_value("b2b_data", data, 8'h0F);

        // Short low pulse is rejected as a false start.
        hold_line(1'b0, 4);
        check_value("glitch_start_busy", busy, 1);
        hold_line(1'b1, 6);
        check_value("glitch_start_busy_mid", busy, 1);
        hold_line(1'b1, 6);
        check_value("glitch_start_idle", busy, 0);

        // Stop bit held low for three bit periods.
        send_bad_frame(8'h3C, 3);
        check_value("break_seen", exp_q.size(), 0);
        check_value("break_data_kept", data, 8'h0F);
        hold_line(1'b1, 4);

        // Reset in the middle of data bit 4 of 0xFF, then a clean frame.
        send_bit(1'b0, -1);
        for (int i = 0; i < 4; i++) send_bit(1'b1, -1);
        hold_line(1'b1, 8);
        reset = 1'b1;
        one_tick();
        check_value("midrst_busy", busy, 0);
        check_value("midrst_data", data, 0);
        check_value("midrst_valid", valid, 0);
        reset     = 1'b0;
        last_good = '0;
        hold_line(1'b1, 100);
        check_value("midrst_idle", busy, 0);
        send_frame(8'h81, 0);
        hold_line(1'b1, 4);
        check_value("after_rst_data", data, 8'h81);

        // One-tick glitch inside every mid-bit window.
        send_frame(8'h96, 1);
        hold_line(1'b1, 4);
        check_value("glitch_frame_data", data, 8'h96);

        // Randomized frames with varying tick spacing.
        for (int f = 0; f < 24; f++) begin
            k_div = int'($urandom_range(1, 3));
            if ($urandom_range(0, 9) == 0) begin
                send_bad_frame(DB'($urandom), int'($urandom_range(1, 3)));
                hold_line(1'b1, 4);
            end else begin
                send_frame(DB'($urandom), 2);
                hold_line(1'b1, int'($urandom_range(0, 12)));
            end
        end

        hold_line(1'b1, 40);
        check_value("all_events_seen", exp_q.size(), 0);
        check_value("final_busy", busy, 0);
        check_value("final_data", data, last_good);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
